// File: rtl/znmi_pkg.sv
// Shared constants for the NMI controller: FSM encoding, NMI vector address, counter width.
package znmi_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PULSE  = 3'd1;
    localparam logic [2:0] ST_WAIT66 = 3'd2;
    localparam logic [2:0] ST_ENTRY  = 3'd3;
    localparam logic [2:0] ST_ACTIVE = 3'd4;
    localparam logic [2:0] ST_EXIT   = 3'd5;

    localparam logic [15:0] ADDR_NMI = 16'h0066;

    // Shared by pulse length, fetch timeout and refresh countdown; sized for TMO up to 255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/znmi_if.sv
// Bus bundle between the Z80 side / request sources and the NMI controller.
interface znmi_if #(parameter int NCH = 4);
    logic            zpos;
    logic            zneg;
    logic            int_start;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  imm_mask;
    logic            clr_nmi;
    logic            m1_n;
    logic            mreq_n;
    logic            rfsh_n;
    logic [15:0]     a;
    logic            drive_00;
    logic            in_nmi;
    logic            gen_nmi;
    logic            nmi_buf_clr;
    logic [2:0]      cause;
    logic [NCH-1:0]  pend;

    modport master (
        output zpos, zneg, int_start, req, imm_mask, clr_nmi, m1_n, mreq_n, rfsh_n, a,
        input  drive_00, in_nmi, gen_nmi, nmi_buf_clr, cause, pend
    );

    modport slave (
        input  zpos, zneg, int_start, req, imm_mask, clr_nmi, m1_n, mreq_n, rfsh_n, a,
        output drive_00, in_nmi, gen_nmi, nmi_buf_clr, cause, pend
    );
endinterface

// File: rtl/znmi_arb.sv
// Per-channel request edge detect, pending flags and lowest-index-first arbiter.
module znmi_arb #(parameter int NCH = 4) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_i,
    input  logic [NCH-1:0] imm_mask_i,
    input  logic           int_start_i,
    input  logic           sel_en_i,
    output logic [NCH-1:0] pend_o,
    output logic           grant_o,
    output logic [2:0]     grant_idx_o
);
    logic [NCH-1:0] req_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] clr;
    logic           found;

    always_comb begin
        elig        = pend_q & (imm_mask_i | {NCH{int_start_i}});
        clr         = '0;
        found       = 1'b0;
        grant_idx_o = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_en_i && elig[i] && !found) begin
                found       = 1'b1;
                clr[i]      = 1'b1;
                grant_idx_o = 3'(i);
            end
        end
        grant_o = found;
        // A new edge wins over the clear of the same bit, so it is never lost.
        pend_d  = (pend_q & ~clr) | (req_i & ~req_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= req_i;
            pend_q <= '0;
        end else begin
            req_q  <= req_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/znmi_mc.sv
// Multi-channel NMI controller: arbitrates requests, pulses NMI_N, tracks the 0066 entry and the exit.
module znmi_mc
    import znmi_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int NMI_LEN  = 4,
    parameter int CLR_RFSH = 2,
    parameter int TMO      = 255
) (
    input  logic  fclk,
    input  logic  rst,
    znmi_if.slave bus
);
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cause_q, cause_d;
    logic             in_nmi_q, in_nmi_d;
    logic             was_0066_q, was_0066_d;
    logic             m1_s_q, mreq_s_q, m1mreq_q;
    logic             rfsh_s_q, rfsh_d_q, rfsh_dd_q;
    logic             m1mreq, m1_rise, addr_hit, rfsh_fall;
    logic             grant;
    logic [2:0]       grant_idx;

    znmi_arb #(.NCH(NCH)) u_arb (
        .clk         (fclk),
        .rst         (rst),
        .req_i       (bus.req),
        .imm_mask_i  (bus.imm_mask),
        .int_start_i (bus.int_start),
        .sel_en_i    (state_q == ST_IDLE),
        .pend_o      (bus.pend),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign addr_hit   = (bus.a == ADDR_NMI);
    assign m1mreq     = m1_s_q & mreq_s_q;
    assign m1_rise    = m1mreq & ~m1mreq_q;
    assign rfsh_fall  = rfsh_dd_q & ~rfsh_d_q;
    assign was_0066_d = m1_rise ? addr_hit : was_0066_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        in_nmi_d = in_nmi_q;
        case (state_q)
            ST_IDLE: if (grant) begin
                state_d = ST_PULSE;
                cnt_d   = CNT_W'(NMI_LEN);
                cause_d = grant_idx;
            end
            ST_PULSE: if (bus.zpos) begin
                if (cnt_q <= 1) begin
                    state_d = ST_WAIT66;
                    cnt_d   = CNT_W'(TMO);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT66: begin
                if (m1_rise && addr_hit) begin
                    state_d = ST_ENTRY;
                    cnt_d   = '0;
                end else if (bus.zpos) begin
                    if (cnt_q <= 1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_ENTRY: if (rfsh_fall && was_0066_q) begin
                state_d  = ST_ACTIVE;
                in_nmi_d = 1'b1;
            end
            ST_ACTIVE: if (bus.clr_nmi) begin
                state_d = ST_EXIT;
                cnt_d   = CNT_W'(CLR_RFSH);
            end
            ST_EXIT: begin
                // A repeated exit write restarts the refresh countdown.
                if (bus.clr_nmi) begin
                    cnt_d = CNT_W'(CLR_RFSH);
                end else if (rfsh_fall) begin
                    if (cnt_q <= 1) begin
                        state_d  = ST_IDLE;
                        in_nmi_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cause_q    <= 3'd0;
            in_nmi_q   <= 1'b0;
            was_0066_q <= 1'b0;
            m1_s_q     <= 1'b0;
            mreq_s_q   <= 1'b0;
            m1mreq_q   <= 1'b0;
            rfsh_s_q   <= 1'b1;
            rfsh_d_q   <= 1'b1;
            rfsh_dd_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            in_nmi_q   <= in_nmi_d;
            was_0066_q <= was_0066_d;
            if (bus.zpos) begin
                m1_s_q   <= ~bus.m1_n;
                rfsh_s_q <= bus.rfsh_n;
            end
            if (bus.zneg) mreq_s_q <= ~bus.mreq_n;
            m1mreq_q  <= m1mreq;
            rfsh_d_q  <= rfsh_s_q;
            rfsh_dd_q <= rfsh_d_q;
        end
    end

    assign bus.drive_00    = (state_q == ST_ENTRY) & ~bus.m1_n & ~bus.mreq_n & addr_hit;
    assign bus.in_nmi      = in_nmi_q;
    assign bus.gen_nmi     = (state_q == ST_PULSE);
    assign bus.nmi_buf_clr = (state_q == ST_ENTRY) & was_0066_q;
    assign bus.cause       = cause_q;

endmodule

// File: tb/tb_znmi_mc.sv
// Directed bench for znmi_mc: Z80 T-states are four fclk (zpos, idle, zneg, idle).
module tb_znmi_mc;
    logic fclk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    always #5 fclk = ~fclk;

    znmi_if #(.NCH(4)) bus();

    znmi_mc #(.NCH(4), .NMI_LEN(4), .CLR_RFSH(2), .TMO(255)) dut (
        .fclk (fclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic zt();
        bus.zpos = 1'b1; tick();
        bus.zpos = 1'b0; tick();
        bus.zneg = 1'b1; tick();
        bus.zneg = 1'b0; tick();
    endtask

    // One M1 cycle: T1/T2 fetch at addr, T3 refresh, T4 idle.
    task automatic fetch(input logic [15:0] addr, output logic drv, output logic bclr);
        bus.a = addr; bus.m1_n = 1'b0; bus.mreq_n = 1'b0;
        zt();
        drv  = bus.drive_00;
        bclr = bus.nmi_buf_clr;
        zt();
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.rfsh_n = 1'b0; bus.a = 16'h0012;
        zt();
        bus.rfsh_n = 1'b1;
        zt();
        bus.a = 16'h0000;
    endtask

    task automatic run_pulse(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.gen_nmi) break;
            n++;
            zt();
        end
    endtask

    task automatic clr();
        bus.clr_nmi = 1'b1; tick();
        bus.clr_nmi = 1'b0;
    endtask

    task automatic do_exit();
        logic d, b;
        clr();
        fetch(16'h0100, d, b);
        fetch(16'h0100, d, b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.zpos = 0; bus.zneg = 0; bus.int_start = 0; bus.req = 4'b0000;
        bus.imm_mask = 4'b1110; bus.clr_nmi = 0;
        bus.m1_n = 1; bus.mreq_n = 1; bus.rfsh_n = 1; bus.a = 16'h0000;
        tick(); tick();
        tot_cnt++; if (bus.in_nmi !== 1'b0) $display("FAIL rst_in_nmi: got %b want 0", bus.in_nmi); else pass_cnt++;
        tot_cnt++; if (bus.gen_nmi !== 1'b0) $display("FAIL rst_gen_nmi: got %b want 0", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b0000) $display("FAIL rst_pend: got %b want 0000", bus.pend); else pass_cnt++;
        tot_cnt++; if (bus.cause !== 3'd0) $display("FAIL rst_cause: got %0d want 0", bus.cause); else pass_cnt++;
        tot_cnt++; if (bus.nmi_buf_clr !== 1'b0) $display("FAIL rst_bufclr: got %b want 0", bus.nmi_buf_clr); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_imm_ch2();
        int n;
        logic d, b;
        bus.req[2] = 1'b1;
        tick();
        tot_cnt++; if (bus.pend !== 4'b0100) $display("FAIL ch2_pend: got %b want 0100", bus.pend); else pass_cnt++;
        tick();
        tot_cnt++; if (bus.gen_nmi !== 1'b1) $display("FAIL ch2_gen: got %b want 1", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b0000) $display("FAIL ch2_pend_clr: got %b want 0000", bus.pend); else pass_cnt++;
        run_pulse(n);
        tot_cnt++; if (n !== 4) $display("FAIL ch2_pulse_len: got %0d want 4", n); else pass_cnt++;
        fetch(16'h0066, d, b);
        tot_cnt++; if (d !== 1'b1) $display("FAIL ch2_drive00: got %b want 1", d); else pass_cnt++;
        tot_cnt++; if (b !== 1'b1) $display("FAIL ch2_bufclr: got %b want 1", b); else pass_cnt++;
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL ch2_in_nmi: got %b want 1", bus.in_nmi); else pass_cnt++;
        tot_cnt++; if (bus.cause !== 3'd2) $display("FAIL ch2_cause: got %0d want 2", bus.cause); else pass_cnt++;
        clr();
        fetch(16'h0100, d, b);
        tot_cnt++; if (d !== 1'b0) $display("FAIL ch2_no_drive: got %b want 0", d); else pass_cnt++;
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL ch2_exit1: got %b want 1", bus.in_nmi); else pass_cnt++;
        fetch(16'h0100, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b0) $display("FAIL ch2_exit2: got %b want 0", bus.in_nmi); else pass_cnt++;
        bus.req[2] = 1'b0;
        tick();
    endtask

    task automatic test_deferred_ch0();
        int n;
        logic d, b;
        bus.req[0] = 1'b1;
        repeat (10) tick();
        tot_cnt++; if (bus.gen_nmi !== 1'b0) $display("FAIL def_wait: got %b want 0", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b0001) $display("FAIL def_pend: got %b want 0001", bus.pend); else pass_cnt++;
        bus.int_start = 1'b1; tick();
        bus.int_start = 1'b0;
        tot_cnt++; if (bus.gen_nmi !== 1'b1) $display("FAIL def_gen: got %b want 1", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.cause !== 3'd0) $display("FAIL def_cause: got %0d want 0", bus.cause); else pass_cnt++;
        run_pulse(n);
        fetch(16'h0066, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL def_in_nmi: got %b want 1", bus.in_nmi); else pass_cnt++;
        do_exit();
        bus.req[0] = 1'b0;
        tick();
    endtask

    task automatic test_two_ch();
        int n;
        logic d, b;
        bus.req[1] = 1'b1; bus.req[3] = 1'b1;
        tick(); tick();
        tot_cnt++; if (bus.cause !== 3'd1) $display("FAIL two_first: got %0d want 1", bus.cause); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b1000) $display("FAIL two_pend: got %b want 1000", bus.pend); else pass_cnt++;
        run_pulse(n);
        fetch(16'h0066, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL two_in_nmi1: got %b want 1", bus.in_nmi); else pass_cnt++;
        clr();
        fetch(16'h0100, d, b);
        fetch(16'h0100, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b0) $display("FAIL two_exit: got %b want 0", bus.in_nmi); else pass_cnt++;
        tot_cnt++; if (bus.gen_nmi !== 1'b1) $display("FAIL two_second_gen: got %b want 1", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.cause !== 3'd3) $display("FAIL two_second_cause: got %0d want 3", bus.cause); else pass_cnt++;
        run_pulse(n);
        fetch(16'h0066, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL two_in_nmi3: got %b want 1", bus.in_nmi); else pass_cnt++;
        do_exit();
        bus.req[1] = 1'b0; bus.req[3] = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        logic d, b;
        logic seen;
        bus.req[2] = 1'b1;
        tick(); tick();
        tot_cnt++; if (bus.gen_nmi !== 1'b1) $display("FAIL tmo_gen: got %b want 1", bus.gen_nmi); else pass_cnt++;
        run_pulse(n);
        seen = 1'b0;
        repeat (254) begin
            zt();
            if (bus.in_nmi || bus.drive_00) seen = 1'b1;
        end
        bus.req[3] = 1'b1;
        tick(); tick();
        tot_cnt++; if (bus.gen_nmi !== 1'b0) $display("FAIL tmo_still_wait: got %b want 0", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b1000) $display("FAIL tmo_pend: got %b want 1000", bus.pend); else pass_cnt++;
        zt();
        if (bus.in_nmi || bus.drive_00) seen = 1'b1;
        tot_cnt++; if (seen !== 1'b0) $display("FAIL tmo_no_map: got %b want 0", seen); else pass_cnt++;
        tot_cnt++; if (bus.gen_nmi !== 1'b1) $display("FAIL tmo_idle_regen: got %b want 1", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.cause !== 3'd3) $display("FAIL tmo_cause: got %0d want 3", bus.cause); else pass_cnt++;
        run_pulse(n);
        fetch(16'h0066, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL tmo_after_in_nmi: got %b want 1", bus.in_nmi); else pass_cnt++;
        do_exit();
        bus.req[2] = 1'b0; bus.req[3] = 1'b0;
        tick();
    endtask

    task automatic test_exit_reload();
        int n;
        logic d, b;
        bus.req[1] = 1'b1;
        tick(); tick();
        run_pulse(n);
        fetch(16'h0066, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL rel_in_nmi: got %b want 1", bus.in_nmi); else pass_cnt++;
        clr();
        fetch(16'h0100, d, b);
        clr();
        fetch(16'h0100, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL rel_after1: got %b want 1", bus.in_nmi); else pass_cnt++;
        fetch(16'h0100, d, b);
        tot_cnt++; if (bus.in_nmi !== 1'b0) $display("FAIL rel_after2: got %b want 0", bus.in_nmi); else pass_cnt++;
        bus.req[1] = 1'b0;
        tick();
    endtask

    task automatic test_rst_active();
        int n;
        logic d, b;
        bus.req[2] = 1'b1;
        tick(); tick();
        run_pulse(n);
        fetch(16'h0066, d, b);
        bus.req[0] = 1'b1;
        tick(); tick();
        tot_cnt++; if (bus.in_nmi !== 1'b1) $display("FAIL ra_in_nmi: got %b want 1", bus.in_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b0001) $display("FAIL ra_pend: got %b want 0001", bus.pend); else pass_cnt++;
        rst = 1'b1; tick();
        tot_cnt++; if (bus.in_nmi !== 1'b0) $display("FAIL ra_rst_in_nmi: got %b want 0", bus.in_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b0000) $display("FAIL ra_rst_pend: got %b want 0000", bus.pend); else pass_cnt++;
        tot_cnt++; if (bus.cause !== 3'd0) $display("FAIL ra_rst_cause: got %0d want 0", bus.cause); else pass_cnt++;
        rst = 1'b0;
        repeat (5) tick();
        bus.int_start = 1'b1; tick();
        bus.int_start = 1'b0; tick();
        tot_cnt++; if (bus.gen_nmi !== 1'b0) $display("FAIL ra_no_regen: got %b want 0", bus.gen_nmi); else pass_cnt++;
        tot_cnt++; if (bus.pend !== 4'b0000) $display("FAIL ra_no_pend: got %b want 0000", bus.pend); else pass_cnt++;
        bus.req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_imm_ch2();
        test_deferred_ch0();
        test_two_ch();
        test_timeout();
        test_exit_reload();
        test_rst_active();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/znmi_mc.md
ZNMI_MC -- requirements
Module: znmi_mc

Interface
REQ-001 Parameters: NCH, default 4, number of NMI request channels (2..8).
REQ-002 Parameters: NMI_LEN, default 4, NMI_N low pulse length in zpos strobes (1..15).
REQ-003 Parameters: CLR_RFSH, default 2, refresh cycles between clr_nmi and in_nmi drop (1..3).
REQ-004 Parameters: TMO, default 255, zpos strobes allowed from pulse end to the 0066 fetch before abort.
REQ-005 Ports:
- fclk  in  1  system clock; one clock only.
- rst  in  1  reset, synchronous, active-high.
- zpos, zneg  in  1  Z80 clock edge strobes, one fclk wide.
- int_start  in  1  frame INT start strobe.
- req  in  NCH  per-channel NMI request level; a request is a 0->1 edge.
- imm_mask  in  NCH  per-channel mode: 1 = immediate, 0 = deferred to next int_start.
- clr_nmi  in  1  NMI exit strobe, from the port write.
- m1_n, mreq_n, rfsh_n  in  1  Z80 bus controls.
- a  in  16  Z80 address.
- drive_00  out  1  drive NOP onto the data bus.
- in_nmi  out  1  NMI RAM page mapped at 0000-3FFF.
- gen_nmi  out  1  1 = NMI_N low.
- nmi_buf_clr  out  1  clear the read buffer during entry.
- cause  out  3  index of the channel that was served; valid while in_nmi=1.
- pend  out  NCH  pending flags.

Function
REQ-006 Channel edge detect: req is registered every fclk; a 0->1 edge sets pend[i] on the next fclk.
REQ-007 Deferred channels (imm_mask[i]=0) are eligible only on an int_start cycle; immediate channels are eligible at once.
REQ-008 Selection: the lowest eligible index wins while the FSM is IDLE; the winner's pend bit clears and its index is latched into cause.
REQ-009 pend bits of channels that were not served persist; they are served one at a time after return to IDLE.
REQ-010 An edge on the same fclk as its clear leaves pend set.
REQ-011 FSM states: IDLE, PULSE, WAIT66, ENTRY, ACTIVE, EXIT.
REQ-012 IDLE->PULSE on selection.
- gen_nmi=1 for exactly NMI_LEN zpos strobes.
- Then ->WAIT66.
REQ-013 M1 tracking: m1_n sampled on zpos, mreq_n sampled on zneg, rfsh_n sampled on zpos then delayed 1 fclk.
- The rising edge of (m1 & mreq) latches was_0066 = (a==16'h0066).
- rfsh_fall is a 1->0 transition of the delayed rfsh_n sample.
REQ-014 WAIT66->ENTRY when an M1 fetch at 0066 starts.
- WAIT66->IDLE (abort, cause unchanged, no mapping) when the TMO count expires first.
REQ-015 drive_00 = ENTRY & !m1_n & !mreq_n & a==16'h0066; this output is combinational.
REQ-016 nmi_buf_clr = 1 in ENTRY while was_0066=1.
REQ-017 ENTRY->ACTIVE on rfsh_fall with was_0066=1; in_nmi goes 1 on the same edge.
REQ-018 A clr_nmi strobe in ACTIVE loads CLR_RFSH into the countdown; state ->EXIT.
- Each rfsh_fall decrements the count.
- At zero, in_nmi goes 0 and state ->IDLE.
REQ-019 clr_nmi is ignored in states other than ACTIVE and EXIT; in EXIT it reloads the countdown.
REQ-020 New requests during PULSE..EXIT only set pend; no nested NMI is generated.
REQ-021 int_start and selection in the same fclk: deferred and immediate channels compete together, lowest index wins.

Reset
REQ-022 On rst, all state is cleared on the next fclk edge, including during an in-flight NMI:
- FSM = IDLE; pend = 0; cause = 0; counters = 0.
- in_nmi, gen_nmi, nmi_buf_clr = 0.
- Registered req = current req, so a level held through reset does not produce an edge.

Structure
REQ-023 State encoding and the 0066 address constant live in the shared package znmi_pkg.
REQ-024 One sub-module: znmi_arb, the NCH-wide edge detect, pend and fixed-priority arbiter.

Verification
REQ-025 Channel 2 immediate edge:
- gen_nmi high for 4 zpos strobes.
- Fetch at 0066: drive_00=1 during that M1 and in_nmi=1 at the following rfsh_fall.
- cause=2.
REQ-026 Channel 0 deferred edge mid-frame: no gen_nmi until int_start, then gen_nmi on the next fclk.
REQ-027 Channels 1 and 3 edges on the same fclk:
- Channel 1 is served first.
- After clr_nmi plus 2 rfsh_falls, in_nmi=0.
- Channel 3 is then served with cause=3.
REQ-028 Pulse with no 0066 fetch for 255 zpos strobes: FSM returns to IDLE; in_nmi and drive_00 stay 0 throughout.
REQ-029 rst asserted in ACTIVE: in_nmi=0, pend=0, gen_nmi=0 one fclk later; req held high through reset does not produce a new NMI.
REQ-030 clr_nmi during EXIT after 1 rfsh_fall: the countdown reloads, and in_nmi drops only after 2 further rfsh_falls.
